// File: rtl/trace_mon_pkg.sv
// Shared constants and hook encoding for the per-core retire-trace monitor.
// Holds the l.nop hook opcodes, the r3 index and the hook classifier.
package trace_mon_pkg;

    localparam logic [15:0] NOP_OPC_HI = 16'h1500;
    localparam logic [15:0] NOP_EXIT   = 16'h0001;
    localparam logic [15:0] NOP_REPORT = 16'h0002;
    localparam logic [15:0] NOP_PUTC   = 16'h0004;
    localparam logic [4:0]  R3_IDX     = 5'd3;

    typedef enum logic [1:0] {
        HK_NONE,
        HK_EXIT,
        HK_REPORT,
        HK_PUTC
    } hook_e;

    // Classifies an instruction word; anything that is not a known l.nop hook is HK_NONE.
    function automatic hook_e classify_hook(input logic [31:0] insn);
        hook_e kind;
        kind = HK_NONE;
        if (insn[31:16] == NOP_OPC_HI) begin
            case (insn[15:0])
                NOP_EXIT:   kind = HK_EXIT;
                NOP_REPORT: kind = HK_REPORT;
                NOP_PUTC:   kind = HK_PUTC;
                default:    kind = HK_NONE;
            endcase
        end
        return kind;
    endfunction

endpackage

// File: rtl/trace_r3_shadow.sv
// Shadow register for GPR r3, loaded from qualified writeback traffic.
// The new value is visible the cycle after the write; there is no bypass.
module trace_r3_shadow
    import trace_mon_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] data,
    output logic [31:0] r3
);

    logic load;

    assign load = valid && we && (addr == R3_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r3 <= '0;
        end else if (load) begin
            r3 <= data;
        end
    end

endmodule

// File: rtl/trace_r3_monitor.sv
// Per-core retire-trace monitor: r3 shadow, l.nop hook strobes, sticky termination.
// Optional retired-instruction counter enabled by TRACE_R3_MON_INSN_COUNT_EN.
module trace_r3_monitor
    import trace_mon_pkg::*;
#(
    parameter int ID             = 0,
    parameter int TERM_CROSS_NUM = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid,
    input  logic                      we,
    input  logic [4:0]                addr,
    input  logic [31:0]               data,
    input  logic [31:0]               wb_pc,
    input  logic [31:0]               wb_insn,
    input  logic [TERM_CROSS_NUM-1:0] termination_all,
    output logic [31:0]               r3,
    output logic                      exit_valid,
    output logic [31:0]               exit_code,
    output logic [31:0]               exit_id,
    output logic                      report_valid,
    output logic [31:0]               report_data,
    output logic                      char_valid,
    output logic [7:0]                char_data,
    output logic                      termination,
    output logic                      all_terminated,
    output logic [31:0]               insn_count
);

    hook_e hook;
    logic  unused_pc;

    assign unused_pc = ^wb_pc;

    trace_r3_shadow u_shadow (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (valid),
        .we    (we),
        .addr  (addr),
        .data  (data),
        .r3    (r3)
    );

    // Hooks are only honoured on a real retire from a core that has not yet exited.
    always_comb begin
        hook = HK_NONE;
        if (valid && !termination) begin
            hook = classify_hook(wb_insn);
        end
    end

    // Captures use the pre-retire r3, which is exactly what the shadow holds this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exit_valid   <= 1'b0;
            exit_code    <= '0;
            report_valid <= 1'b0;
            report_data  <= '0;
            char_valid   <= 1'b0;
            char_data    <= '0;
            termination  <= 1'b0;
        end else begin
            exit_valid   <= (hook == HK_EXIT);
            report_valid <= (hook == HK_REPORT);
            char_valid   <= (hook == HK_PUTC);
            if (hook == HK_EXIT) begin
                exit_code   <= r3;
                termination <= 1'b1;
            end
            if (hook == HK_REPORT) begin
                report_data <= r3;
            end
            if (hook == HK_PUTC) begin
                char_data <= r3[7:0];
            end
        end
    end

    assign exit_id        = 32'(ID);
    assign all_terminated = &termination_all;

`ifdef TRACE_R3_MON_INSN_COUNT_EN
    // The exit retire is still counted because termination rises only after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            insn_count <= '0;
        end else if (valid && !termination) begin
            insn_count <= insn_count + 32'd1;
        end
    end
`else
    assign insn_count = 32'd0;
`endif

endmodule

// File: tb/tb_trace_r3_monitor.sv
// Scoreboard bench for trace_r3_monitor (ID=5, two-core termination vector).
// Expected count follows TRACE_R3_MON_INSN_COUNT_EN when the bench is built with it.
module tb_trace_r3_monitor;

    localparam int TB_ID = 5;
    localparam int NCORE = 2;

    typedef struct {
        logic [31:0] r3;
        logic        exit_v;
        logic [31:0] exit_code;
        logic        report_v;
        logic [31:0] report_data;
        logic        char_v;
        logic [7:0]  char_data;
        logic        term;
        logic [31:0] count;
    } expect_t;

    logic             clk;
    logic             rst_n;
    logic             valid;
    logic             we;
    logic [4:0]       addr;
    logic [31:0]      data;
    logic [31:0]      wb_pc;
    logic [31:0]      wb_insn;
    logic [NCORE-1:0] termination_all;
    logic [31:0]      r3;
    logic             exit_valid;
    logic [31:0]      exit_code;
    logic [31:0]      exit_id;
    logic             report_valid;
    logic [31:0]      report_data;
    logic             char_valid;
    logic [7:0]       char_data;
    logic             termination;
    logic             all_terminated;
    logic [31:0]      insn_count;

    int errors = 0;
    int checks = 0;

    expect_t exp_q[$];

    logic [31:0] m_r3;
    logic [31:0] m_exit_code;
    logic [31:0] m_report;
    logic [7:0]  m_char;
    logic        m_term;
    logic [31:0] m_count;

    trace_r3_monitor #(
        .ID             (TB_ID),
        .TERM_CROSS_NUM (NCORE)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid           (valid),
        .we              (we),
        .addr            (addr),
        .data            (data),
        .wb_pc           (wb_pc),
        .wb_insn         (wb_insn),
        .termination_all (termination_all),
        .r3              (r3),
        .exit_valid      (exit_valid),
        .exit_code       (exit_code),
        .exit_id         (exit_id),
        .report_valid    (report_valid),
        .report_data     (report_data),
        .char_valid      (char_valid),
        .char_data       (char_data),
        .termination     (termination),
        .all_terminated  (all_terminated),
        .insn_count      (insn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, req);
        end
    endtask

    task automatic modelReset();
        m_r3        = '0;
        m_exit_code = '0;
        m_report    = '0;
        m_char      = '0;
        m_term      = 1'b0;
        m_count     = '0;
    endtask

    // Drives one cycle of trace traffic and queues what the monitor must show after the edge.
    task automatic applyStimulus(input logic v, input logic w, input logic [4:0] a,
                                 input logic [31:0] d, input logic [31:0] insn);
        expect_t e;
        logic    is_hook;
        @(negedge clk);
        valid   = v;
        we      = w;
        addr    = a;
        data    = d;
        wb_insn = insn;
        wb_pc   = wb_pc + 32'd4;
        is_hook     = v && !m_term && (insn[31:16] == 16'h1500);
        e.exit_v    = is_hook && (insn[15:0] == 16'h0001);
        e.report_v  = is_hook && (insn[15:0] == 16'h0002);
        e.char_v    = is_hook && (insn[15:0] == 16'h0004);
        if (e.exit_v)   m_exit_code = m_r3;
        if (e.report_v) m_report    = m_r3;
        if (e.char_v)   m_char      = m_r3[7:0];
`ifdef TRACE_R3_MON_INSN_COUNT_EN
        if (v && !m_term) m_count = m_count + 32'd1;
`endif
        if (v && w && a == 5'd3) m_r3 = d;
        if (e.exit_v) m_term = 1'b1;
        e.r3          = m_r3;
        e.exit_code   = m_exit_code;
        e.report_data = m_report;
        e.char_data   = m_char;
        e.term        = m_term;
        e.count       = m_count;
        exp_q.push_back(e);
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        checkOutput("drain", 32'(exp_q.size()), 32'd0);
    endtask

    always @(posedge clk) begin
        expect_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checkOutput("r3",          r3,                 e.r3);
            checkOutput("exit_valid",  32'(exit_valid),    32'(e.exit_v));
            checkOutput("exit_code",   exit_code,          e.exit_code);
            checkOutput("report_valid",32'(report_valid),  32'(e.report_v));
            checkOutput("report_data", report_data,        e.report_data);
            checkOutput("char_valid",  32'(char_valid),    32'(e.char_v));
            checkOutput("char_data",   32'(char_data),     32'(e.char_data));
            checkOutput("termination", 32'(termination),   32'(e.term));
            checkOutput("insn_count",  insn_count,         e.count);
        end
    end

    initial begin
        logic [31:0] cnt_req;
        logic [4:0]  ra;
        logic [15:0] k;
        rst_n           = 1'b0;
        valid           = 1'b0;
        we              = 1'b0;
        addr            = '0;
        data            = '0;
        wb_pc           = 32'h0000_1000;
        wb_insn         = '0;
        termination_all = '0;
        modelReset();

        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_r3",   r3,                 32'd0);
        checkOutput("rst_term", 32'(termination),   32'd0);
        checkOutput("rst_cnt",  insn_count,         32'd0);
        checkOutput("rst_exit", 32'(exit_valid),    32'd0);
        checkOutput("rst_char", 32'(char_valid),    32'd0);
        checkOutput("exit_id",  exit_id,            32'(TB_ID));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 32'h1800_0000);
        for (int i = 0; i < 3; i++)  applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'h1800_0000);
        waitDrain();
`ifdef TRACE_R3_MON_INSN_COUNT_EN
        cnt_req = 32'd10;
`else
        cnt_req = 32'd0;
`endif
        checkOutput("cnt10", insn_count, cnt_req);

        applyStimulus(1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 32'h1800_0000);
        applyStimulus(1'b1, 1'b1, 5'd4, 32'h0000_0000, 32'h1800_0000);
        applyStimulus(1'b0, 1'b1, 5'd3, 32'h1234_5678, 32'h1800_0000);
        applyStimulus(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h1800_0000);
        applyStimulus(1'b1, 1'b1, 5'd3, 32'h0000_0141, 32'h1800_0000);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0,         32'h1500_0004);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0,         32'h1800_0000);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0,         32'h1500_0002);
        applyStimulus(1'b1, 1'b1, 5'd3, 32'h0000_0262, 32'h1800_0000);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0,         32'h1500_0004);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0,         32'h1500_0002);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0,         32'h1500_0003);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0,         32'h1501_0004);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0,         32'h1500_0004);

        for (int i = 0; i < 30; i++) begin
            ra = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       k = 16'h0002;
                1:       k = 16'h0004;
                default: k = 16'($urandom_range(5, 16'hFFFF));
            endcase
            if ($urandom_range(0, 1) == 0)
                applyStimulus(1'($urandom_range(0, 1)), 1'b1, ra, $urandom, {16'h1800, 16'($urandom)});
            else
                applyStimulus(1'($urandom_range(0, 1)), 1'b0, 5'd0, 32'd0, {16'h1500, k});
        end

        applyStimulus(1'b1, 1'b1, 5'd3, 32'd7, 32'h1800_0000);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 32'h1500_0001);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 32'h1500_0004);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 32'h1500_0002);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 32'h1500_0001);
        applyStimulus(1'b1, 1'b1, 5'd3, 32'hCAFE_F00D, 32'h1800_0000);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 32'h1500_0004);
        waitDrain();
        checkOutput("exit_code7", exit_code, 32'd7);

        @(negedge clk);
        termination_all = 2'b01;
        #1 checkOutput("all_01", 32'(all_terminated), 32'd0);
        termination_all = 2'b10;
        #1 checkOutput("all_10", 32'(all_terminated), 32'd0);
        termination_all = 2'b11;
        #1 checkOutput("all_11", 32'(all_terminated), 32'd1);
        termination_all = 2'b00;
        #1 checkOutput("all_00", 32'(all_terminated), 32'd0);

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_term", 32'(termination), 32'd0);
        checkOutput("mid_rst_r3",   r3,               32'd0);
        checkOutput("mid_rst_cnt",  insn_count,       32'd0);
        checkOutput("mid_rst_code", exit_code,        32'd0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b1, 1'b1, 5'd3, 32'h0000_00A5, 32'h1800_0000);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0,         32'h1500_0004);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0,         32'h1500_0001);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0,         32'h1800_0000);
        waitDrain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
